// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment capture block: segment codes,
// active-low digit selects, digit slot indices and the conversion FSM states.
package seven_segment_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    localparam logic [6:0] SEG_CODES [10] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4,
                                              SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};

    localparam logic [3:0] SEL_THOUSANDS = 4'b1110;
    localparam logic [3:0] SEL_HUNDREDS  = 4'b1101;
    localparam logic [3:0] SEL_TENS      = 4'b1011;
    localparam logic [3:0] SEL_UNITS     = 4'b0111;
    localparam logic [3:0] SEL_BLANK     = 4'b1111;

    localparam logic [1:0] IDX_THOUSANDS = 2'd0;
    localparam logic [1:0] IDX_HUNDREDS  = 2'd1;
    localparam logic [1:0] IDX_TENS      = 2'd2;
    localparam logic [1:0] IDX_UNITS     = 2'd3;

    typedef enum logic [1:0] {
        COLLECT,
        CONVERT,
        DONE
    } state_t;

endpackage

// File: rtl/seven_segment_pattern_decode.sv
// Combinational decode of an active-low 7-bit segment pattern (g..a) into a
// BCD digit plus a flag saying whether the pattern is one of the ten legal codes.
module seven_segment_pattern_decode
    import seven_segment_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       legal
);

    always_comb begin
        digit = 4'd0;
        legal = 1'b1;
        case (pattern)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Samples a multiplexed 4-digit seven-segment bus and publishes the value 0..9999.
// Optional macro SEVEN_SEGMENT_CAPTURE_CONFIRM_EN: publish only after two identical frames.
module seven_segment_capture
    import seven_segment_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  sseg_in,
    input  logic [3:0]  cseg_in,
    output logic [13:0] value_out,
    output logic        decimal_out,
    output logic        value_valid,
    output logic        digit_error
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] SAMPLE_AT  = CW'(SETTLE_CYCLES - 1);

    logic [7:0]    sseg_sync [SYNC_STAGES];
    logic [3:0]    cseg_sync [SYNC_STAGES];
    logic [7:0]    sseg_s;
    logic [3:0]    cseg_s;
    logic [3:0]    cseg_prev;
    logic [CW-1:0] settle_cnt;
    logic          sample_event;
    logic          sel_valid;
    logic [1:0]    sel_idx;
    logic [3:0]    pat_digit;
    logic          pat_legal;
    logic          sample_ok;
    logic          sample_err;
    logic [3:0]    mask;
    logic [3:0]    mask_next;
    logic [3:0]    digits [4];
    logic [3:0]    snap [4];
    logic          dp_pending;
    logic          snap_dp;
    logic [13:0]   acc;
    logic [1:0]    conv_idx;
    logic [16:0]   acc_wide;
    logic          acc_unused;
    logic          start_snapshot;
    state_t        state;
    state_t        next_state;
`ifdef SEVEN_SEGMENT_CAPTURE_CONFIRM_EN
    logic [13:0]   prev_frame;
    logic          prev_valid;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sseg_sync[i] <= '1;
                cseg_sync[i] <= SEL_BLANK;
            end
        end else begin
            sseg_sync[0] <= sseg_in;
            cseg_sync[0] <= cseg_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sseg_sync[i] <= sseg_sync[i-1];
                cseg_sync[i] <= cseg_sync[i-1];
            end
        end
    end

    assign sseg_s = sseg_sync[SYNC_STAGES-1];
    assign cseg_s = cseg_sync[SYNC_STAGES-1];

    // The equality term keeps a stale count from firing on the first cycle of a new select.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cseg_prev  <= SEL_BLANK;
            settle_cnt <= '0;
        end else begin
            cseg_prev <= cseg_s;
            if (cseg_s != cseg_prev) begin
                settle_cnt <= '0;
            end else if (settle_cnt != SETTLE_MAX) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    assign sample_event = (cseg_s == cseg_prev) && (settle_cnt == SAMPLE_AT);

    seven_segment_pattern_decode u_decode (
        .pattern (sseg_s[6:0]),
        .digit   (pat_digit),
        .legal   (pat_legal)
    );

    always_comb begin
        sel_valid = 1'b1;
        sel_idx   = IDX_UNITS;
        case (cseg_s)
            SEL_THOUSANDS: sel_idx = IDX_THOUSANDS;
            SEL_HUNDREDS:  sel_idx = IDX_HUNDREDS;
            SEL_TENS:      sel_idx = IDX_TENS;
            SEL_UNITS:     sel_idx = IDX_UNITS;
            default:       sel_valid = 1'b0;
        endcase
    end

    assign sample_ok  = sample_event && (cseg_s != SEL_BLANK) && sel_valid && pat_legal;
    assign sample_err = sample_event && (cseg_s != SEL_BLANK) && !(sel_valid && pat_legal);

    always_comb begin
        mask_next = mask;
        if (start_snapshot) mask_next = '0;
        if (sample_ok)      mask_next[sel_idx] = 1'b1;
        if (sample_err)     mask_next = '0;
    end

    always_comb begin
        next_state     = state;
        start_snapshot = 1'b0;
        case (state)
            COLLECT: begin
                if (mask == 4'hF) begin
                    start_snapshot = 1'b1;
                    next_state     = CONVERT;
                end
            end
            CONVERT: if (conv_idx == IDX_UNITS) next_state = DONE;
            DONE:    next_state = COLLECT;
            default: next_state = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= COLLECT;
        else       state <= next_state;
    end

    assign acc_wide   = {acc, 3'b000} + {2'b00, acc, 1'b0} + {13'd0, snap[conv_idx]};
    assign acc_unused = ^acc_wide[16:14];

    // Digit slots keep filling while the snapshot feeds the conversion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask        <= '0;
            dp_pending  <= 1'b0;
            snap_dp     <= 1'b0;
            acc         <= '0;
            conv_idx    <= '0;
            value_out   <= '0;
            decimal_out <= 1'b0;
            value_valid <= 1'b0;
            digit_error <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                digits[i] <= '0;
                snap[i]   <= '0;
            end
`ifdef SEVEN_SEGMENT_CAPTURE_CONFIRM_EN
            prev_frame  <= '0;
            prev_valid  <= 1'b0;
`endif
        end else begin
            mask        <= mask_next;
            digit_error <= sample_err;
            value_valid <= 1'b0;
            if (sample_ok) begin
                digits[sel_idx] <= pat_digit;
                if (sel_idx == IDX_THOUSANDS) dp_pending <= ~sseg_s[7];
            end
            if (start_snapshot) begin
                snap     <= digits;
                snap_dp  <= dp_pending;
                acc      <= '0;
                conv_idx <= '0;
            end
            if (state == CONVERT) begin
                acc      <= acc_wide[13:0];
                conv_idx <= conv_idx + 1'b1;
            end
            if (state == DONE) begin
`ifdef SEVEN_SEGMENT_CAPTURE_CONFIRM_EN
                if (prev_valid && (prev_frame == acc)) begin
                    value_out   <= acc;
                    decimal_out <= snap_dp;
                    value_valid <= 1'b1;
                end else begin
                    prev_frame <= acc;
                    prev_valid <= 1'b1;
                end
`else
                value_out   <= acc;
                decimal_out <= snap_dp;
                value_valid <= 1'b1;
`endif
            end
`ifdef SEVEN_SEGMENT_CAPTURE_CONFIRM_EN
            if (sample_err) prev_valid <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Randomized self-checking bench for seven_segment_capture against a
// digit-level reference model (frame value = 1000a+100b+10c+d).
module tb_seven_segment_capture;
    import seven_segment_pkg::*;

    localparam int SETTLE = 16;
    localparam int SYNC   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  sseg_in;
    logic [3:0]  cseg_in;
    logic [13:0] value_out;
    logic        decimal_out;
    logic        value_valid;
    logic        digit_error;

    logic [6:0]  chk_pattern;
    logic [3:0]  chk_digit;
    logic        chk_legal;

    seven_segment_capture #(
        .SETTLE_CYCLES (SETTLE),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sseg_in     (sseg_in),
        .cseg_in     (cseg_in),
        .value_out   (value_out),
        .decimal_out (decimal_out),
        .value_valid (value_valid),
        .digit_error (digit_error)
    );

    seven_segment_pattern_decode decode_chk (
        .pattern (chk_pattern),
        .digit   (chk_digit),
        .legal   (chk_legal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         num_compared   = 0;
    int         num_mismatched = 0;
    int         valid_seen     = 0;
    int         last_exp_edge  = 0;
    int         m_dig [4];
    logic [3:0] m_mask;
    bit         m_dp;
    bit         m_prev_valid;
    int         m_prev;
    logic [3:0] last_cseg;
    bit         exp_v   [int];
    int         exp_val [int];
    bit         exp_dp  [int];
    bit         exp_e   [int];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_compared++;
        if (observed !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (value_valid) valid_seen++;
            if (value_valid || exp_v.exists(cyc)) begin
                checkOutput("value_valid", 32'(value_valid), 32'(exp_v.exists(cyc)));
                if (exp_v.exists(cyc)) begin
                    checkOutput("value_out", 32'(value_out), 32'(exp_val[cyc]));
                    checkOutput("decimal_out", 32'(decimal_out), 32'(exp_dp[cyc]));
                end
            end
            if (digit_error || exp_e.exists(cyc))
                checkOutput("digit_error", 32'(digit_error), 32'(exp_e.exists(cyc)));
        end
    end

    function automatic int slotOf(input logic [3:0] cseg);
        case (cseg)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [3:0] selOf(input int slot);
        logic [3:0] sel;
        sel = 4'b1111;
        sel[slot] = 1'b0;
        return sel;
    endfunction

    function automatic int digitOf(input logic [6:0] pat);
        for (int d = 0; d < 10; d++)
            if (SEG_CODES[d] == pat) return d;
        return -1;
    endfunction

    task automatic modelSample(input logic [3:0] cseg, input logic [7:0] sseg, input int e);
        int slot;
        int d;
        int val;
        if (cseg == 4'b1111) return;
        slot = slotOf(cseg);
        d    = digitOf(sseg[6:0]);
        if (slot < 0 || d < 0) begin
            exp_e[e]     = 1'b1;
            m_mask       = '0;
            m_prev_valid = 1'b0;
            if (e > last_exp_edge) last_exp_edge = e;
            return;
        end
        m_dig[slot]  = d;
        m_mask[slot] = 1'b1;
        if (slot == 0) m_dp = ~sseg[7];
        if (m_mask == 4'hF) begin
            m_mask = '0;
            val = m_dig[0] * 1000 + m_dig[1] * 100 + m_dig[2] * 10 + m_dig[3];
`ifdef SEVEN_SEGMENT_CAPTURE_CONFIRM_EN
            if (!(m_prev_valid && m_prev == val)) begin
                m_prev       = val;
                m_prev_valid = 1'b1;
                return;
            end
`endif
            exp_v[e+6]   = 1'b1;
            exp_val[e+6] = val;
            exp_dp[e+6]  = m_dp;
            if (e + 6 > last_exp_edge) last_exp_edge = e + 6;
        end
    endtask

    task automatic driveHold(input logic [3:0] cseg, input logic [7:0] sseg,
                             input int dwell, output int e);
        @(negedge clk);
        cseg_in = cseg;
        sseg_in = sseg;
        e = -1;
        if (cseg != last_cseg && dwell >= SETTLE + 1) begin
            e = cyc + 1 + SYNC + SETTLE;
            modelSample(cseg, sseg, e);
        end
        last_cseg = cseg;
    endtask

    task automatic applyStimulus(input logic [3:0] cseg, input logic [7:0] sseg, input int dwell);
        int e;
        driveHold(cseg, sseg, dwell, e);
        repeat (dwell - 1) @(negedge clk);
    endtask

    task automatic sendFrame(input int value, input bit dp, input int dwell,
                             input int bad_slot, input logic [6:0] bad_pat);
        int         dv [4];
        logic [6:0] pat;
        logic       b7;
        dv[0] = (value / 1000) % 10;
        dv[1] = (value / 100) % 10;
        dv[2] = (value / 10) % 10;
        dv[3] = value % 10;
        for (int s = 0; s < 4; s++) begin
            pat = (s == bad_slot) ? bad_pat : SEG_CODES[dv[s]];
            b7  = (s == 0) ? ~dp : 1'($urandom_range(0, 1));
            applyStimulus(selOf(s), {b7, pat}, dwell);
        end
    endtask

    task automatic applyReset(input int cycles);
        @(negedge clk);
        #2;
        reset   = 1'b1;
        cseg_in = 4'b1111;
        sseg_in = 8'hFF;
        #1;
        checkOutput("reset_value_out", 32'(value_out), 0);
        checkOutput("reset_decimal_out", 32'(decimal_out), 0);
        checkOutput("reset_value_valid", 32'(value_valid), 0);
        checkOutput("reset_digit_error", 32'(digit_error), 0);
        exp_v.delete();
        exp_val.delete();
        exp_dp.delete();
        exp_e.delete();
        m_mask       = '0;
        m_dp         = 1'b0;
        m_prev_valid = 1'b0;
        last_cseg    = 4'b1111;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        while (cyc <= last_exp_edge + 2 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) checkOutput("drain_timeout", 32'(guard), 0);
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [6:0] randomIllegal();
        logic [6:0] p;
        do p = 7'($urandom_range(0, 127)); while (digitOf(p) >= 0);
        return p;
    endfunction

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int v0;
        int e;
        int value;
        int dwell;
        logic [6:0] pat;

        reset     = 1'b1;
        cseg_in   = 4'b1111;
        sseg_in   = 8'hFF;
        last_cseg = 4'b1111;
        m_mask    = '0;
        m_dp      = 1'b0;
        m_prev_valid = 1'b0;
        m_prev    = 0;
        chk_pattern = 7'h7F;
        applyReset(3);

        for (int d = 0; d < 10; d++) begin
            chk_pattern = SEG_CODES[d];
            #1;
            checkOutput("decode_digit", 32'(chk_digit), d);
            checkOutput("decode_legal", 32'(chk_legal), 1);
        end
        chk_pattern = 7'h7F;
        #1 checkOutput("decode_illegal_7F", 32'(chk_legal), 0);
        chk_pattern = 7'h41;
        #1 checkOutput("decode_illegal_41", 32'(chk_legal), 0);

        $display("[TB] frame 1234 with long dwell");
        sendFrame(1234, 1'b0, 1501, -1, 7'h00);
        sendFrame(9999, 1'b1, SETTLE + 5, -1, 7'h00);
        sendFrame(0, 1'b0, SETTLE + 9, -1, 7'h00);
        waitDrain();

        $display("[TB] short dwell, no sample");
        v0 = valid_seen;
        sendFrame(4567, 1'b1, SETTLE - 2, -1, 7'h00);
        waitDrain();
        checkOutput("short_dwell_strobes", 32'(valid_seen - v0), 0);

        $display("[TB] illegal tens pattern then clean frame");
        sendFrame(5678, 1'b0, SETTLE + 3, 2, 7'h7F);
        sendFrame(5678, 1'b0, SETTLE + 3, -1, 7'h00);
        waitDrain();

        $display("[TB] reset during conversion");
        applyStimulus(SEL_THOUSANDS, {1'b1, SEG_3}, SETTLE + 4);
        applyStimulus(SEL_HUNDREDS, {1'b1, SEG_1}, SETTLE + 4);
        applyStimulus(SEL_TENS, {1'b1, SEG_4}, SETTLE + 4);
        driveHold(SEL_UNITS, {1'b1, SEG_1}, 1000, e);
        while (cyc < e + 3) @(negedge clk);
        applyReset(4);
        sendFrame(2718, 1'b1, SETTLE + 6, -1, 7'h00);
        waitDrain();

        $display("[TB] illegal select 1100");
        applyStimulus(4'b1100, {1'b1, SEG_3}, SETTLE + 10);
        sendFrame(8080, 1'b0, SETTLE + 2, -1, 7'h00);
        waitDrain();

        $display("[TB] random frames");
        for (int f = 0; f < 12; f++) begin
            value = $urandom_range(0, 9999);
            for (int s = 0; s < 4; s++) begin
                dwell = ($urandom_range(0, 7) == 0) ? SETTLE - 2 : $urandom_range(SETTLE + 1, SETTLE + 30);
                case (s)
                    0: pat = SEG_CODES[(value / 1000) % 10];
                    1: pat = SEG_CODES[(value / 100) % 10];
                    2: pat = SEG_CODES[(value / 10) % 10];
                    default: pat = SEG_CODES[value % 10];
                endcase
                if ($urandom_range(0, 9) == 0) pat = randomIllegal();
                applyStimulus(selOf(s), {1'($urandom_range(0, 1)), pat}, dwell);
            end
        end
        waitDrain();

        $display("[TB] confirm sequence 4321 4322 4322");
        sendFrame(7777, 1'b0, SETTLE + 2, 1, 7'h7F);
        waitDrain();
        v0 = valid_seen;
        sendFrame(4321, 1'b0, SETTLE + 4, -1, 7'h00);
        sendFrame(4322, 1'b0, SETTLE + 4, -1, 7'h00);
        sendFrame(4322, 1'b0, SETTLE + 4, -1, 7'h00);
        waitDrain();
`ifdef SEVEN_SEGMENT_CAPTURE_CONFIRM_EN
        checkOutput("confirm_strobes", 32'(valid_seen - v0), 1);
`else
        checkOutput("confirm_strobes", 32'(valid_seen - v0), 3);
`endif
        checkOutput("final_value_out", 32'(value_out), 4322);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Receive-side counterpart to the multiplexed 4-digit seven-segment display bus.
- Samples external active-low segment and digit-select lines, decodes each digit pattern and rebuilds the binary value 0..9999.
- Publishes the value with a one-cycle valid strobe.
- Used for board self-test loopback and for reading externally driven displays into the falcon datapath.

Parameters:
- SETTLE_CYCLES, 16: cycles the digit select must be stable before the segment pattern is sampled (range 2..65535).
- SYNC_STAGES, 2: flip-flop synchronizer depth on sseg_in and cseg_in (minimum 2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sseg_in  input  8  segment lines, active-low; bit7 = decimal point, bits6:0 = g..a
- cseg_in  input  4  digit select, active-low; 1110 thousands, 1101 hundreds, 1011 tens, 0111 units
- value_out  output  14  last published binary value
- decimal_out  output  1  decimal point state captured with the thousands digit (1 = lit)
- value_valid  output  1  one-cycle strobe; value_out and decimal_out updated in the same cycle
- digit_error  output  1  one-cycle strobe on an illegal pattern or illegal select

Behaviour:
- Reset values: value_out=0, decimal_out=0, value_valid=0, digit_error=0, FSM=COLLECT, digit mask=0000, settle counter=0.
- Reset is asynchronous at any point, including mid-CONVERT, and aborts the frame in progress.
- Inputs pass through SYNC_STAGES flops; all logic below uses the synchronized copies.
- Settle counter:
  - Cleared whenever synchronized cseg differs from its previous-cycle value; otherwise increments, saturating at SETTLE_CYCLES.
  - The sample event fires on the single cycle the counter reaches SETTLE_CYCLES-1, so each select hold is sampled exactly once.
- At the sample event:
  - cseg = 1111 (blanked): no action, no error.
  - cseg not one-hot-low: digit_error pulse, mask cleared.
  - sseg[6:0] not among the ten legal codes: digit_error pulse, mask cleared.
  - Legal codes (hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Otherwise the decoded digit is written to its slot and the mask bit is set.
  - The thousands sample also latches dp_pending = ~sseg[7].
  - Repeat samples of the same slot overwrite the slot.
- FSM states:
  - COLLECT
    - Edge E sets the mask to 1111.
    - Edge E+1: snapshot the four digits and dp_pending, clear the mask, acc=0, idx=0, go to CONVERT.
  - CONVERT
    - Edges E+2..E+5: acc = (acc<<3)+(acc<<1)+snap[idx], idx thousands→units.
    - Compute in 17 bits and keep the low 14; the maximum is 9999.
    - After idx 3, go to DONE.
  - DONE
    - Edge E+6: value_out=acc, decimal_out=snapshot dp, value_valid=1; return to COLLECT.
    - Latency from the last digit sample edge to the valid strobe is 6 cycles.
- Capture continues during CONVERT/DONE into the digit slots; the snapshot isolates conversion.
- A mask completed during CONVERT/DONE is held and serviced on return to COLLECT.
- An error during CONVERT/DONE clears only the mask; the conversion in progress completes.
- value_valid and digit_error may assert in the same cycle.

Optional Feature:
- Macro SEVEN_SEGMENT_CAPTURE_CONFIRM_EN.
- Defined:
  - DONE publishes only if acc equals the previous converted frame (a held register, cleared by reset and by any digit_error).
  - A mismatch stores acc as the new previous frame without strobing.
  - The first valid follows the second identical frame.
- Undefined: every completed frame publishes.

Decomposition:
- Package seven_segment_pkg holds:
  - the ten segment code constants
  - the four active-low select constants
  - the FSM state enum (COLLECT, CONVERT, DONE)
  - digit index constants
- One sub-module: seven_segment_pattern_decode. It is combinational, maps 7-bit pattern to 4-bit digit plus legal flag, and is reused by the bench checker.

Test Plan:
- Bench multiplexer cycles 1234 (dwell 1501 cycles per digit, dp off) → value_valid with value_out=1234 and decimal_out=0, 6 cycles after the units sample edge.
- 9999 with dp lit on thousands, then 0000 → value_out 9999 with decimal_out=1, then 0 with decimal_out=0; no digit_error.
- Dwell of SETTLE_CYCLES-2 per digit → no sample, no value_valid, no digit_error.
- Inject pattern 7F on the tens digit of 5678 → digit_error pulse, no publish for that frame; next clean frame publishes 5678.
- Assert reset during CONVERT → all outputs 0 immediately; next full frame publishes normally.
- cseg 1100 held for the settle period → digit_error.
- With CONFIRM_EN: frames 4321, 4322, 4322 → a single value_valid, carrying 4322.
